// File: rtl/answer_disp_pkg.sv
// ============================================================================
//  answer_disp_pkg
//  Seven-segment constants, hex encoder and parameter derivation helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package answer_disp_pkg;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;

    function automatic int num_digits(input int answer_width);
        return answer_width / 4;
    endfunction

    function automatic int max_ofs(input int answer_width, input int window_digits);
        return (answer_width / 4) - window_digits;
    endfunction

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
//  button_conditioner
//  Two-flop synchroniser, debounce counter and one-cycle press pulse.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    output logic o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_button;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample agreeing with the accepted level restarts the run
            if (r_sync2 != r_level) begin
                if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/answer_window_scroller.sv
// ============================================================================
//  answer_window_scroller
//  Scrollable hex window onto a captured answer with zero blanking and flags.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module answer_window_scroller
    import answer_disp_pkg::*;
#(
    parameter int ANSWER_WIDTH      = 32,
    parameter int WINDOW_DIGITS     = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int AUTOSCROLL_PERIOD = 50000000
) (
    input  logic                                     IN_clk,
    input  logic                                     IN_reset_n,
    input  logic [ANSWER_WIDTH-1:0]                  IN_binary_answer,
    input  logic                                     IN_answer_valid,
    input  logic                                     IN_up_button,
    input  logic                                     IN_down_button,
    input  logic                                     IN_center_button,
    output logic [7*WINDOW_DIGITS-1:0]               OUT_window_segs,
    output logic [ANSWER_WIDTH/4-WINDOW_DIGITS:0]    OUT_Led_Visualizer,
    output logic                                     OUT_more_above,
    output logic                                     OUT_more_below,
    output logic                                     OUT_auto_mode
);

    localparam int c_NUM_DIGITS = num_digits(ANSWER_WIDTH);
    localparam int c_MAX_OFS    = max_ofs(ANSWER_WIDTH, WINDOW_DIGITS);
    localparam int c_LED_W      = c_MAX_OFS + 1;
    localparam int c_OFS_W      = (c_MAX_OFS > 0) ? $clog2(c_MAX_OFS + 1) : 1;
    localparam int c_TMR_W      = (AUTOSCROLL_PERIOD > 1) ? $clog2(AUTOSCROLL_PERIOD) : 1;

    logic                        w_up;
    logic                        w_down;
    logic                        w_center;
    logic [ANSWER_WIDTH-1:0]     r_answer;
    logic [c_OFS_W-1:0]          r_offset;
    logic                        r_auto;
    logic [c_TMR_W-1:0]          r_timer;

    int                          w_msd;
    logic [7*WINDOW_DIGITS-1:0]  w_segs;
    logic [7*WINDOW_DIGITS-1:0]  w_rst_segs;
    logic [c_LED_W-1:0]          w_led;
    logic                        w_above;
    logic                        w_below;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(IN_clk), .rst_n(IN_reset_n), .i_button(IN_up_button), .o_press(w_up)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(IN_clk), .rst_n(IN_reset_n), .i_button(IN_down_button), .o_press(w_down)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center (
        .clk(IN_clk), .rst_n(IN_reset_n), .i_button(IN_center_button), .o_press(w_center)
    );

    // Priority: capture > up/down > centre > auto step
    always_ff @(posedge IN_clk) begin
        if (!IN_reset_n) begin
            r_answer <= '0;
            r_offset <= '0;
            r_auto   <= 1'b0;
            r_timer  <= '0;
        end else if (IN_answer_valid) begin
            r_answer <= IN_binary_answer;
            r_offset <= '0;
            r_timer  <= '0;
        end else if (w_up || w_down) begin
            r_auto  <= 1'b0;
            r_timer <= '0;
            if (w_up && !w_down && (int'(r_offset) < c_MAX_OFS)) begin
                r_offset <= r_offset + c_OFS_W'(1);
            end else if (w_down && !w_up && (r_offset != '0)) begin
                r_offset <= r_offset - c_OFS_W'(1);
            end
        end else if (w_center) begin
            r_auto  <= ~r_auto;
            r_timer <= '0;
        end else if (r_auto) begin
            if (r_timer == c_TMR_W'(AUTOSCROLL_PERIOD - 1)) begin
                r_timer  <= '0;
                r_offset <= (int'(r_offset) >= c_MAX_OFS) ? '0 : r_offset + c_OFS_W'(1);
            end else begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

    always_comb begin
        w_msd   = 0;
        w_below = 1'b0;
        for (int i = 0; i < c_NUM_DIGITS; i++) begin
            if (4'(r_answer >> (4 * i)) != 4'h0) begin
                w_msd = i;
                if (i < int'(r_offset)) begin
                    w_below = 1'b1;
                end
            end
        end
        w_above = (w_msd > int'(r_offset) + WINDOW_DIGITS - 1);

        // Index 0 can never exceed msd, so it is never blanked
        w_segs = '0;
        for (int k = 0; k < WINDOW_DIGITS; k++) begin
            if (int'(r_offset) + k > w_msd) begin
                w_segs[7*k +: 7] = c_SEG_BLANK;
            end else begin
                w_segs[7*k +: 7] = hex_to_seg(4'(r_answer >> (4 * (int'(r_offset) + k))));
            end
        end

        w_rst_segs       = {WINDOW_DIGITS{c_SEG_BLANK}};
        w_rst_segs[6:0]  = c_SEG_ZERO;
        w_led            = c_LED_W'(1) << r_offset;
    end

    always_ff @(posedge IN_clk) begin
        if (!IN_reset_n) begin
            OUT_window_segs    <= w_rst_segs;
            OUT_Led_Visualizer <= c_LED_W'(1);
            OUT_more_above     <= 1'b0;
            OUT_more_below     <= 1'b0;
        end else begin
            OUT_window_segs    <= w_segs;
            OUT_Led_Visualizer <= w_led;
            OUT_more_above     <= w_above;
            OUT_more_below     <= w_below;
        end
    end

    assign OUT_auto_mode = r_auto;

endmodule

`default_nettype wire

// File: tb/tb_answer_window_scroller.sv
// ============================================================================
//  tb_answer_window_scroller
//  Directed scoreboard bench for the scrolling answer window.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_answer_window_scroller;

    localparam int AW  = 32;
    localparam int WD  = 4;
    localparam int DBC = 4;
    localparam int ASP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] answer;
    logic        valid;
    logic        up;
    logic        down;
    logic        center;
    logic [27:0] segs;
    logic [4:0]  led;
    logic        above;
    logic        below;
    logic        auto_m;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [27:0] segs;
        logic [4:0]  led;
        logic        above;
        logic        below;
        logic        auto_m;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    answer_window_scroller #(
        .ANSWER_WIDTH(AW), .WINDOW_DIGITS(WD),
        .DEBOUNCE_CYCLES(DBC), .AUTOSCROLL_PERIOD(ASP)
    ) dut (
        .IN_clk(clk),
        .IN_reset_n(rst_n),
        .IN_binary_answer(answer),
        .IN_answer_valid(valid),
        .IN_up_button(up),
        .IN_down_button(down),
        .IN_center_button(center),
        .OUT_window_segs(segs),
        .OUT_Led_Visualizer(led),
        .OUT_more_above(above),
        .OUT_more_below(below),
        .OUT_auto_mode(auto_m)
    );

    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic exp_t model(input string tag, input logic [31:0] ans,
                                   input int ofs, input logic am);
        exp_t        e;
        int          msd;
        logic [3:0]  d;
        logic [31:0] sh;
        msd = 0;
        for (int i = 7; i >= 0; i--) begin
            sh = ans >> (4 * i);
            if (sh[3:0] != 4'h0 && msd == 0) msd = i;
        end
        e.tag   = tag;
        e.below = 1'b0;
        for (int i = 0; i < ofs; i++) begin
            sh = ans >> (4 * i);
            if (sh[3:0] != 4'h0) e.below = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            sh = ans >> (4 * (ofs + k));
            d  = sh[3:0];
            e.segs[7*k +: 7] = (ofs + k > msd) ? 7'b1111111 : seg7(d);
        end
        e.above  = (msd > ofs + 3);
        e.led    = 5'b00001 << ofs;
        e.auto_m = am;
        return e;
    endfunction

    function automatic exp_t raw(input string tag, input logic [27:0] s, input logic [4:0] l,
                                 input logic a, input logic b, input logic am);
        exp_t e;
        e.tag = tag; e.segs = s; e.led = l; e.above = a; e.below = b; e.auto_m = am;
        return e;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".segs"},  32'(segs),   32'(e.segs));
            cmp({e.tag, ".led"},   32'(led),    32'(e.led));
            cmp({e.tag, ".above"}, 32'(above),  32'(e.above));
            cmp({e.tag, ".below"}, 32'(below),  32'(e.below));
            cmp({e.tag, ".auto"},  32'(auto_m), 32'(e.auto_m));
        end
    endtask

    task automatic capture(input logic [31:0] a);
        answer = a;
        valid  = 1'b1;
        tick();
        valid  = 1'b0;
        tick();
    endtask

    // which: bit0 up, bit1 down, bit2 centre
    task automatic press(input int which, input int hold);
        up     = which[0];
        down   = which[1];
        center = which[2];
        tick(hold);
        up = 1'b0; down = 1'b0; center = 1'b0;
        tick(12);
    endtask

    localparam logic [27:0] c_RST_SEGS = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};

    initial begin
        rst_n = 1'b0; answer = '0; valid = 1'b0;
        up = 1'b0; down = 1'b0; center = 1'b0;
        tick(3);
        rst_n = 1'b1;
        sb.push_back(raw("reset", c_RST_SEGS, 5'b00001, 1'b0, 1'b0, 1'b0));
        check_out();

        // Test 1: small answer with blanking
        capture(32'h0000_00A5);
        sb.push_back(raw("cap_a5", {7'b1111111, 7'b1111111, 7'b0001000, 7'b0010010},
                         5'b00001, 1'b0, 1'b0, 1'b0));
        check_out();

        // Test 2: scroll up to saturation
        capture(32'h1234_5678);
        sb.push_back(model("cap_1234", 32'h1234_5678, 0, 1'b0));
        check_out();
        press(1, 10);
        sb.push_back(raw("up1", {seg7(4'h4), seg7(4'h5), seg7(4'h6), seg7(4'h7)},
                         5'b00010, 1'b1, 1'b1, 1'b0));
        check_out();
        for (int i = 2; i <= 5; i++) begin
            press(1, 6);
            sb.push_back(model($sformatf("up%0d", i), 32'h1234_5678, (i > 4) ? 4 : i, 1'b0));
            check_out();
        end

        // Test 3: step down, glitch rejected, simultaneous up/down ignored
        press(2, 6);
        sb.push_back(model("down3", 32'h1234_5678, 3, 1'b0));
        check_out();
        press(1, 3);
        sb.push_back(model("glitch", 32'h1234_5678, 3, 1'b0));
        check_out();
        press(3, 10);
        sb.push_back(model("updown", 32'h1234_5678, 3, 1'b0));
        check_out();

        // Test 4: auto-scroll with wrap, then down press exits auto
        center = 1'b1;
        tick(5);
        center = 1'b0;
        tick(3);
        sb.push_back(model("auto_on", 32'h1234_5678, 3, 1'b1));
        check_out();
        tick(7);
        sb.push_back(model("auto_pre", 32'h1234_5678, 3, 1'b1));
        check_out();
        tick(1);
        sb.push_back(model("auto_4", 32'h1234_5678, 4, 1'b1));
        check_out();
        tick(8);
        sb.push_back(model("auto_wrap", 32'h1234_5678, 0, 1'b1));
        check_out();
        down = 1'b1;
        tick(5);
        down = 1'b0;
        tick(3);
        sb.push_back(model("auto_down", 32'h1234_5678, 0, 1'b0));
        check_out();
        tick(12);
        sb.push_back(model("auto_off", 32'h1234_5678, 0, 1'b0));
        check_out();

        // Test 5: capture wins over a simultaneous up press
        press(1, 6);
        press(1, 6);
        sb.push_back(model("ofs2", 32'h1234_5678, 2, 1'b0));
        check_out();
        up = 1'b1;
        tick(5);
        up = 1'b0;
        tick(1);
        answer = 32'hFFFF_FFFF;
        valid  = 1'b1;
        tick(1);
        valid  = 1'b0;
        tick(1);
        sb.push_back(raw("cap_prio", {4{7'b0001110}}, 5'b00001, 1'b1, 1'b0, 1'b0));
        check_out();
        tick(12);
        sb.push_back(raw("cap_hold", {4{7'b0001110}}, 5'b00001, 1'b1, 1'b0, 1'b0));
        check_out();

        // Test 6: reset during auto mode at offset 3
        press(1, 6);
        press(1, 6);
        press(1, 6);
        center = 1'b1;
        tick(5);
        center = 1'b0;
        tick(3);
        sb.push_back(model("pre_rst", 32'hFFFF_FFFF, 3, 1'b1));
        check_out();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        sb.push_back(raw("mid_rst", c_RST_SEGS, 5'b00001, 1'b0, 1'b0, 1'b0));
        check_out();
        tick(20);
        sb.push_back(raw("post_rst", c_RST_SEGS, 5'b00001, 1'b0, 1'b0, 1'b0));
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/answer_window_scroller.md
Name: answer_window_scroller

Overview:
Parametrised answer display block for the calculator seven-segment path. It captures an ANSWER_WIDTH-bit result and splits it into hex digits. It presents a WINDOW_DIGITS-wide window of segment codes, scrolled by debounced up/down buttons or by a timed auto-scroll mode toggled with the centre button. It adds leading-zero blanking, a one-hot window-position LED bar, and flags for hidden non-zero digits beyond the window.

Parameters:
ANSWER_WIDTH, 32, answer width in bits; must be a multiple of 4; NUM_DIGITS = ANSWER_WIDTH/4
WINDOW_DIGITS, 4, digits shown at once; 1 <= WINDOW_DIGITS <= NUM_DIGITS; MAX_OFS = NUM_DIGITS - WINDOW_DIGITS
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a button level is accepted
AUTOSCROLL_PERIOD, 50000000, cycles between auto-scroll steps

Ports:
IN_clk  in  1  clock
IN_reset_n  in  1  synchronous reset, active-low
IN_binary_answer  in  ANSWER_WIDTH  answer from the calculator
IN_answer_valid  in  1  one-cycle strobe; capture IN_binary_answer
IN_up_button  in  1  raw button; scrolls toward more-significant digits
IN_down_button  in  1  raw button; scrolls toward less-significant digits
IN_center_button  in  1  raw button; toggles auto-scroll
OUT_window_segs  out  7*WINDOW_DIGITS  segment codes; slice [7k+6:7k] is window digit k (k=0 least significant); active-low {g,f,e,d,c,b,a}
OUT_Led_Visualizer  out  MAX_OFS+1  one-hot current window offset
OUT_more_above  out  1  a non-zero digit exists above the window
OUT_more_below  out  1  a non-zero digit exists below the window
OUT_auto_mode  out  1  auto-scroll active

Behaviour:
- Reset (IN_reset_n low at a rising edge): answer register = 0; offset = 0; auto = 0; debounce state cleared, accepted levels = 0; scroll timer = 0.
- Reset output values: window digit 0 = 7'b1000000 ("0"); other window digits = 7'b1111111; LED = 1 (bit 0); flags = 0.
- Capture: IN_answer_valid registers the answer, forces offset = 0 and clears the scroll timer. Auto mode is unchanged.
- Button path, per button: 2-FF synchroniser, then a debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it. A press is the accepted level's 0->1 edge, a one-cycle pulse. Release produces no event.
- Up press: offset = min(offset+1, MAX_OFS). Saturates; no wrap.
- Down press: offset = max(offset-1, 0). Saturates.
- Up and down press in the same cycle: offset unchanged.
- Up or down press while auto = 1: clears auto, then applies the step.
- Centre press: toggles auto and clears the scroll timer.
- Auto mode: timer counts 0..AUTOSCROLL_PERIOD-1. On the terminal count, offset = offset+1, or 0 if offset == MAX_OFS (wraps).
- Priority in one cycle: capture > up/down > centre > auto step.
- Digit selection: window digit k shows answer digit offset+k.
- Leading-zero blanking: find msd, the highest non-zero digit index (msd = 0 when the answer is 0). A digit with index > msd displays 7'b1111111. Digit index 0 is never blanked.
- Hex encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- OUT_more_above = (msd > offset+WINDOW_DIGITS-1).
- OUT_more_below = any non-zero digit with index < offset.
- All outputs are registered. Outputs reflect a capture or an offset change one cycle after the causing edge. Total button latency from a raw level change = 2 (synchroniser) + DEBOUNCE_CYCLES + 1 (edge) + 1 (output) cycles.
- MAX_OFS = 0: up/down/auto have no effect on offset; LED = 1'b1.
- Reset mid-debounce or mid-scroll discards all pending state.

Decomposition:
- Package answer_disp_pkg: seven-segment blank constant (7'b1111111), hex-to-segment function, and MAX_OFS/NUM_DIGITS derivation helpers.
- Sub-module button_conditioner: synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES. Instantiated three times.
- Offset/auto FSM and blanking logic live in the top.

Test Plan:
Bench parameters: ANSWER_WIDTH=32, WINDOW_DIGITS=4, DEBOUNCE_CYCLES=4, AUTOSCROLL_PERIOD=8.
1. Reset, then capture 32'h0000_00A5 -> digits k0..3 = 0010010, 0001000, 1111111, 1111111; LED=5'b00001; more_above=0; more_below=0.
2. Capture 32'h1234_5678; up pulse held 10 cycles -> offset 1; window shows 7,6,5,4 (k0..3); more_above=1; more_below=1; LED=5'b00010. Four further up presses -> offset saturates at 4, showing 4,3,2,1; more_above=0.
3. Up glitch held 3 cycles -> no offset change. Up and down both asserted 10 cycles with aligned edges -> offset unchanged.
4. Centre press with offset=3 -> auto=1. After 8 cycles offset=4; after 8 more offset=0 (wrap). Then a down press -> auto=0, offset stays 0.
5. Offset=2 with a button press and IN_answer_valid (32'hFFFF_FFFF) in the same cycle -> offset=0; all four digits = 0001110.
6. Assert IN_reset_n=0 for one cycle during auto mode at offset 3 -> next cycle all outputs equal the reset values listed in Behaviour.
